// File: rtl/mul_iterative_radix.sv
// rtl/mul_iterative_radix.sv - iterative RV32M multiplier retiring BITS_PER_CYCLE multiplier bits per cycle
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-low reset
//   startM          request, sampled only in IDLE or DONE
//   flush           abort the operation in flight; blocks acceptance
//   mul_opcode      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   operand1        rs1, multiplicand
//   operand2        rs2, multiplier
//   result_multiply registered result, held until the next completion
//   done            one-cycle pulse when result_multiply is valid
//   mul_use         busy/stall while CALC/SIGN, or in the cycle a request is accepted
module mul_iterative_radix #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startM,
    input  logic            flush,
    input  logic [1:0]      mul_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result_multiply,
    output logic            done,
    output logic            mul_use
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int SW    = $clog2(STEPS) + 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t          state;
    logic [1:0]      opcode_q;
    logic [2*XLEN-1:0] mcand_q;   // |op1| pre-shifted to the weight of the current digit
    logic [XLEN-1:0] mplier_q;    // |op2|, consumed from the LSB end
    logic            neg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [SW-1:0]   step_q;

    logic            accept;
    logic            op1_neg;
    logic            op2_neg;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [2*XLEN-1:0] pp;

    assign accept  = startM && !flush && (state == S_IDLE || state == S_DONE);
    assign mul_use = (state == S_CALC) || (state == S_SIGN) || accept;

    // op1 is signed for MULH/MULHSU, op2 only for MULH. Negating the most
    // negative value yields the same bit pattern, which read unsigned is the
    // correct magnitude 2^(XLEN-1).
    assign op1_neg = ((mul_opcode == 2'b01) || (mul_opcode == 2'b10)) && operand1[XLEN-1];
    assign op2_neg = (mul_opcode == 2'b01) && operand2[XLEN-1];
    assign abs1    = op1_neg ? -operand1 : operand1;
    assign abs2    = op2_neg ? -operand2 : operand2;

    // Partial product of the multiplicand with the current multiplier digit.
    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                pp = pp + (mcand_q << i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            opcode_q        <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            neg_q           <= 1'b0;
            acc_q           <= '0;
            step_q          <= '0;
            result_multiply <= '0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_q    <= acc_q + pp;
                        mcand_q  <= mcand_q << BITS_PER_CYCLE;
                        mplier_q <= mplier_q >> BITS_PER_CYCLE;
                        step_q   <= step_q + SW'(1);
                        if (step_q == LAST_STEP) begin
                            state <= S_SIGN;
                        end
                    end
                end
                S_SIGN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (neg_q) begin
                            acc_q <= -acc_q;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    result_multiply <= (opcode_q == 2'b00) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
                    done            <= 1'b1;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Acceptance overrides the DONE->IDLE transition for back-to-back use;
            // the DONE branch above already captured the old accumulator.
            if (accept) begin
                opcode_q <= mul_opcode;
                mcand_q  <= {{XLEN{1'b0}}, abs1};
                mplier_q <= abs2;
                neg_q    <= op1_neg ^ op2_neg;
                acc_q    <= '0;
                step_q   <= '0;
                state    <= ((operand1 == '0) || (operand2 == '0)) ? S_DONE : S_CALC;
            end
        end
    end

endmodule

// File: tb/tb_mul_iterative_radix.sv
// tb/tb_mul_iterative_radix.sv - self-checking bench for mul_iterative_radix (radix 1 and radix 4)
module tb_mul_iterative_radix;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            startM;
    logic            flush;
    logic [1:0]      mul_opcode;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [XLEN-1:0] result_multiply;
    logic            done;
    logic            mul_use;
    logic [XLEN-1:0] result4;
    logic            done4;
    logic            mul_use4;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mul_iterative_radix #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .startM(startM), .flush(flush),
        .mul_opcode(mul_opcode), .operand1(operand1), .operand2(operand2),
        .result_multiply(result_multiply), .done(done), .mul_use(mul_use)
    );

    mul_iterative_radix #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .startM(startM), .flush(flush),
        .mul_opcode(mul_opcode), .operand1(operand1), .operand2(operand2),
        .result_multiply(result4), .done(done4), .mul_use(mul_use4)
    );

    // Reference: full-precision product of the operands interpreted per opcode.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] x;
        logic signed [65:0] y;
        logic signed [65:0] p;
        x = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
        y = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
        p = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    // Issues one request and records each instance's result and latency (-1 on timeout).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r1, output int c1, output logic [31:0] r4, output int c4);
        int n;
        mul_opcode = op; operand1 = a; operand2 = b; startM = 1'b1;
        @(posedge clk); #1;
        startM = 1'b0;
        c1 = -1; c4 = -1; r1 = '0; r4 = '0; n = 0;
        while ((c1 < 0 || c4 < 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done && c1 < 0) begin c1 = n; r1 = result_multiply; end
            if (done4 && c4 < 0) begin c4 = n; r4 = result4; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; startM = 1'b0; flush = 1'b0; mul_opcode = '0; operand1 = '0; operand2 = '0;
        #1;
        checks++; if (result_multiply !== 32'h0) $display("FAIL reset_result got=%h exp=0", result_multiply); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        checks++; if (mul_use !== 1'b0) $display("FAIL reset_mul_use got=%b exp=0", mul_use); else passed++;
        checks++; if ({result4, done4, mul_use4} !== 34'h0) $display("FAIL reset_r4 got=%h exp=0", {result4, done4, mul_use4}); else passed++;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [6] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
        logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
        logic [31:0] bs  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007};
        logic [31:0] exp [6] = '{32'hFFFFFFFE, 32'h00000001, 32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFEB};
        logic [31:0] r1, r4;
        int c1, c4;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], r1, c1, r4, c4);
            checks++; if (r1 !== exp[i]) $display("FAIL directed_%0d_result got=%h exp=%h", i, r1, exp[i]); else passed++;
            checks++; if (c1 !== 34) $display("FAIL directed_%0d_latency got=%0d exp=34", i, c1); else passed++;
            checks++; if (r4 !== exp[i]) $display("FAIL directed_%0d_result_r4 got=%h exp=%h", i, r4, exp[i]); else passed++;
            checks++; if (c4 !== 10) $display("FAIL directed_%0d_latency_r4 got=%0d exp=10", i, c4); else passed++;
        end
    endtask

    task automatic test_zero_exit;
        mul_opcode = 2'b01; operand1 = 32'h0; operand2 = 32'h12345678; startM = 1'b1;
        #1;
        checks++; if (mul_use !== 1'b1) $display("FAIL zero_accept_mul_use got=%b exp=1", mul_use); else passed++;
        @(posedge clk); #1;
        startM = 1'b0;
        #1;
        checks++; if (mul_use !== 1'b0) $display("FAIL zero_after_mul_use got=%b exp=0", mul_use); else passed++;
        checks++; if (mul_use4 !== 1'b0) $display("FAIL zero_after_mul_use_r4 got=%b exp=0", mul_use4); else passed++;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) $display("FAIL zero_done got=%b exp=1", done); else passed++;
        checks++; if (result_multiply !== 32'h0) $display("FAIL zero_result got=%h exp=0", result_multiply); else passed++;
        checks++; if (done4 !== 1'b1 || result4 !== 32'h0) $display("FAIL zero_r4 got=%b/%h exp=1/0", done4, result4); else passed++;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) $display("FAIL zero_done_pulse got=%b exp=0", done); else passed++;
    endtask

    task automatic test_ignore_start;
        int n, got;
        logic [31:0] res;
        mul_opcode = 2'b10; operand1 = 32'hFFFFFFFF; operand2 = 32'hFFFFFFFF; startM = 1'b1;
        @(posedge clk); #1;
        startM = 1'b0;
        n = 0; got = -1; res = '0;
        while (got < 0 && n < 200) begin
            if (n == 3) begin startM = 1'b1; mul_opcode = 2'b00; operand1 = 32'd6; operand2 = 32'd7; end
            @(posedge clk); #1;
            n++;
            if (n == 4) startM = 1'b0;
            if (done && got < 0) begin got = n; res = result_multiply; end
        end
        checks++; if (got !== 34) $display("FAIL ignore_latency got=%0d exp=34", got); else passed++;
        checks++; if (res !== 32'hFFFFFFFF) $display("FAIL ignore_result got=%h exp=ffffffff", res); else passed++;
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic test_flush;
        int cnt;
        logic [31:0] r1, r4;
        int c1, c4;
        mul_opcode = 2'b00; operand1 = 32'd3; operand2 = 32'd5; startM = 1'b1;
        @(posedge clk); #1;
        startM = 1'b0;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (mul_use !== 1'b0) $display("FAIL flush_mul_use got=%b exp=0", mul_use); else passed++;
        checks++; if (mul_use4 !== 1'b0) $display("FAIL flush_mul_use_r4 got=%b exp=0", mul_use4); else passed++;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done || done4) cnt++;
        end
        checks++; if (cnt !== 0) $display("FAIL flush_no_done got=%0d exp=0", cnt); else passed++;
        checks++; if (result_multiply !== 32'hFFFFFFFF) $display("FAIL flush_held got=%h exp=ffffffff", result_multiply); else passed++;
        checks++; if (result4 !== 32'hFFFFFFFF) $display("FAIL flush_held_r4 got=%h exp=ffffffff", result4); else passed++;
        run_op(2'b11, 32'h00010000, 32'h00010000, r1, c1, r4, c4);
        checks++; if (r1 !== 32'h1 || c1 !== 34) $display("FAIL flush_next got=%h/%0d exp=1/34", r1, c1); else passed++;
    endtask

    task automatic test_back_to_back;
        int n, got;
        logic [31:0] res;
        mul_opcode = 2'b11; operand1 = 32'hFFFFFFFF; operand2 = 32'hFFFFFFFF; startM = 1'b1;
        @(posedge clk); #1;
        startM = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) $display("FAIL b2b_early_done got=%b exp=0", done); else passed++;
        mul_opcode = 2'b00; operand1 = 32'hFFFFFFFD; operand2 = 32'h7; startM = 1'b1;
        #1;
        checks++; if (mul_use !== 1'b1) $display("FAIL b2b_accept_mul_use got=%b exp=1", mul_use); else passed++;
        @(posedge clk); #1;
        startM = 1'b0;
        checks++; if (done !== 1'b1 || result_multiply !== 32'hFFFFFFFE) $display("FAIL b2b_first got=%b/%h exp=1/fffffffe", done, result_multiply); else passed++;
        n = 0; got = -1; res = '0;
        while (got < 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done) begin got = n; res = result_multiply; end
        end
        checks++; if (got !== 34) $display("FAIL b2b_second_latency got=%0d exp=34", got); else passed++;
        checks++; if (res !== 32'hFFFFFFEB) $display("FAIL b2b_second_result got=%h exp=ffffffeb", res); else passed++;
    endtask

    task automatic test_reset_mid;
        int cnt;
        logic [31:0] r1, r4;
        int c1, c4;
        mul_opcode = 2'b00; operand1 = 32'h1234; operand2 = 32'h5678; startM = 1'b1;
        @(posedge clk); #1;
        startM = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (result_multiply !== 32'h0) $display("FAIL rstmid_result got=%h exp=0", result_multiply); else passed++;
        checks++; if (done !== 1'b0 || mul_use !== 1'b0) $display("FAIL rstmid_ctrl got=%b/%b exp=0/0", done, mul_use); else passed++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || done4) cnt++;
        end
        checks++; if (cnt !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", cnt); else passed++;
        run_op(2'b00, 32'd6, 32'd7, r1, c1, r4, c4);
        checks++; if (r1 !== 32'd42 || c1 !== 34) $display("FAIL rstmid_after got=%0d/%0d exp=42/34", r1, c1); else passed++;
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a, b, exp, r1, r4;
        int c1, c4, l1, l4;
        for (int i = 0; i < 300; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_mul(op, a, b);
            l1  = (a == 0 || b == 0) ? 1 : 34;
            l4  = (a == 0 || b == 0) ? 1 : 10;
            run_op(op, a, b, r1, c1, r4, c4);
            checks++; if (r1 !== exp) $display("FAIL rand_%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, r1, exp); else passed++;
            checks++; if (c1 !== l1) $display("FAIL rand_%0d_latency got=%0d exp=%0d", i, c1, l1); else passed++;
            checks++; if (r4 !== exp) $display("FAIL rand_%0d_result_r4 op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, r4, exp); else passed++;
            checks++; if (c4 !== l4) $display("FAIL rand_%0d_latency_r4 got=%0d exp=%0d", i, c4, l4); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_zero_exit;
        test_ignore_start;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
